// File: rtl/fp_mant_seq_mult.sv
// Sequential shift-and-add multiplier for W-bit normalized mantissas.
// Iteration count comes from an external counter driven via EnC/DoneC.
module fp_mant_seq_mult #(
  parameter int W = 24
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         EnC,
  input  logic         DoneC,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] ProdM,
  output logic         ExpAdj,
  output logic         Guard,
  output logic         Sticky
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, NORM} state_t;

  state_t         state_q;
  logic [W-1:0]   mc_q, q_q, p_q;
  logic [W:0]     sum_d;
  logic [W-1:0]   p_d, q_d;
  logic [2*W-1:0] x_d;

  // {Cy,S} shifted right by one together with Q; Q[0] falls off the end
  assign sum_d = {1'b0, p_q} + (q_q[0] ? {1'b0, mc_q} : {(W+1){1'b0}});
  assign p_d   = sum_d[W:1];
  assign q_d   = {sum_d[0], q_q[W-1:1]};
  assign x_d   = {p_q, q_q};

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      mc_q    <= '0;
      q_q     <= '0;
      p_q     <= '0;
      EnC     <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      ProdM   <= '0;
      ExpAdj  <= 1'b0;
      Guard   <= 1'b0;
      Sticky  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            mc_q    <= A;
            q_q     <= B;
            p_q     <= '0;
            Busy    <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          p_q     <= p_d;
          q_q     <= q_d;
          EnC     <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          // DoneC means W iterations are already in; no further shift
          if (DoneC) begin
            EnC     <= 1'b1;
            state_q <= NORM;
          end else begin
            p_q <= p_d;
            q_q <= q_d;
          end
        end
        NORM: begin
          if (x_d[2*W-1]) begin
            ProdM  <= x_d[2*W-1:W];
            Guard  <= x_d[W-1];
            Sticky <= |x_d[W-2:0];
            ExpAdj <= 1'b1;
          end else begin
            ProdM  <= x_d[2*W-2:W-1];
            Guard  <= x_d[W-2];
            Sticky <= |x_d[W-3:0];
            ExpAdj <= 1'b0;
          end
          Done    <= 1'b1;
          Busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mant_seq_mult.sv
// Randomized self-checking bench for fp_mant_seq_mult with an external 24-step counter model.
module tb_fp_mant_seq_mult;
  localparam int W = 24;

  logic         CLK = 1'b0;
  logic         Reset, Start, EnC, DoneC, Busy, Done, ExpAdj, Guard, Sticky;
  logic [W-1:0] A, B, ProdM;
  logic [5:0]   cnt_q = 6'd0;
  int           n_checks = 0;
  int           n_fail = 0;

  fp_mant_seq_mult #(.W(W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .EnC(EnC), .DoneC(DoneC), .Busy(Busy), .Done(Done),
    .ProdM(ProdM), .ExpAdj(ExpAdj), .Guard(Guard), .Sticky(Sticky)
  );

  always #5 CLK = ~CLK;

  // bit counter: load 1 when EnC, otherwise count up; terminal flag at W
  always @(posedge CLK) cnt_q <= EnC ? 6'd1 : cnt_q + 6'd1;
  assign DoneC = (cnt_q == 6'(W));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // {ProdM, ExpAdj, Guard, Sticky} from the exact product
  function automatic logic [26:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [47:0] p;
    p = 48'(a) * 48'(b);
    if (p[47]) return {p[47:24], 1'b1, p[23], |p[22:0]};
    else       return {p[46:23], 1'b0, p[22], |p[21:0]};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at);
    logic [26:0] expv;
    int n, enc_low, busy_n;
    bit seen;
    expv = ref_mult(a, b);
    A = a; B = b; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; A = W'($urandom); B = W'($urandom);
    check("done_clear", Done, 0);
    check("load_enc", EnC, 1);
    busy_n = Busy; enc_low = 0; seen = 0;
    for (n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      Start = 1'b0;
      if (Done) begin seen = 1; break; end
      enc_low += int'(!EnC);
      busy_n  += int'(Busy);
      if (n == pulse_at) begin A = W'($urandom); B = W'($urandom); Start = 1'b1; end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("latency", n, 26);
    check("enc_low_cycles", enc_low, W);
    check("busy_cycles", busy_n, 26);
    check("busy_at_done", Busy, 0);
    check("prodm", ProdM, expv[26:3]);
    check("expadj", ExpAdj, expv[2]);
    check("guard", Guard, expv[1]);
    check("sticky", Sticky, expv[0]);
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_enc", EnC, 1);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_prodm", ProdM, 0);
    check("rst_flags", {ExpAdj, Guard, Sticky}, 0);
    @(negedge CLK); Reset = 1'b0;
    @(negedge CLK);

    run_op(24'h800000, 24'h800000, 0);
    check("one_x_one", {ProdM, ExpAdj, Guard, Sticky}, {24'h800000, 3'b000});
    @(negedge CLK);
    run_op(24'hC00000, 24'hC00000, 0);
    check("c_x_c", {ProdM, ExpAdj, Guard, Sticky}, {24'h900000, 3'b100});
    @(negedge CLK);
    run_op(24'hFFFFFF, 24'hFFFFFF, 0);
    check("max_x_max", {ProdM, ExpAdj, Guard, Sticky}, {24'hFFFFFE, 3'b101});
    @(negedge CLK);

    // zero operand then back-to-back start in the Done cycle
    run_op(24'h000000, 24'hABCDEF, 0);
    check("zero", {ProdM, ExpAdj, Guard, Sticky}, 27'd0);
    run_op(24'hC00000, 24'hC00000, 0);
    check("b2b_c_x_c", {ProdM, ExpAdj, Guard, Sticky}, {24'h900000, 3'b100});
    @(negedge CLK);

    // Start pulse while busy must not disturb the operation
    run_op(24'hFFFFFF, 24'h800001, 10);
    @(negedge CLK);
    run_op(24'hA5A5A5, 24'hC3C3C3, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("hold_prodm", ProdM, ref_mult(24'hA5A5A5, 24'hC3C3C3) >> 3);

    // reset in the middle of an operation
    A = 24'hFFFFFF; B = 24'hFFFFFF; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    Reset = 1'b1;
    #1;
    check("mid_rst_enc", EnC, 1);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_out", {ProdM, ExpAdj, Guard, Sticky}, 27'd0);
    @(negedge CLK); Reset = 1'b0;
    dones = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      dones += int'(Done);
    end
    check("mid_rst_no_done", dones, 0);
    @(negedge CLK);
    run_op(24'hC00000, 24'hC00000, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      ra = {1'b1, 23'($urandom)};
      rb = {1'b1, 23'($urandom)};
      if (i == 5) ra = '0;
      if (i == 9) rb = '0;
      run_op(ra, rb, (i % 3 == 0) ? int'($urandom_range(2, 20)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
